// File: rtl/rv32imf_mult_pkg.sv
// Shared types for the RV32M multiplier issue path.
// Carries the multiplier operator encoding used across stages.
package rv32imf_mult_pkg;

    typedef enum logic [2:0] {
        MUL_MAC32 = 3'b000,
        MUL_MSU32 = 3'b001,
        MUL_I     = 3'b010,
        MUL_IR    = 3'b011,
        MUL_DOT8  = 3'b100,
        MUL_DOT16 = 3'b101,
        MUL_H     = 3'b110
    } mul_opcode_e;

endpackage

// File: rtl/rv32imf_mult_issue.sv
// Issue/result stage around rv32imf_mult: accepts RV32M MUL/MULH* from
// decode, sequences the 4-step MULH using op_c feedback, and buffers the
// result in a one-entry output register for writeback.
// Ports:
//   clk, rst_n (async, active-low), flush_i
//   in_valid_i/in_ready_o, in_funct3_i, in_rs1_i, in_rs2_i, in_rd_i : decode
//   mult_* : multiplier controls, operands and status
//   out_valid_o/out_ready_i, out_result_o, out_rd_o : writeback
//   busy_o : MULH sequence in flight
module rv32imf_mult_issue
    import rv32imf_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  in_funct3_i,
    input  logic [31:0] in_rs1_i,
    input  logic [31:0] in_rs2_i,
    input  logic [4:0]  in_rd_i,
    output logic        mult_enable_o,
    output mul_opcode_e mult_operator_o,
    output logic [1:0]  mult_short_signed_o,
    output logic [31:0] mult_op_a_o,
    output logic [31:0] mult_op_b_o,
    output logic [31:0] mult_op_c_o,
    output logic        mult_ex_ready_o,
    input  logic [31:0] mult_result_i,
    input  logic        mult_ready_i,
    input  logic        mult_multicycle_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_result_o,
    output logic [4:0]  out_rd_o,
    output logic        busy_o
);

    typedef enum logic {IDLE, MH_WAIT} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_sgn;
    logic [4:0]  r_rd;
    logic [31:0] r_opc;
    logic        r_kill;
    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic [4:0]  r_out_rd;

    mul_opcode_e w_dec_op;
    logic [1:0]  w_dec_sgn;
    logic        w_idle;
    logic        w_accept;
    logic        w_is_mul;
    logic        w_mult_done;
    logic        w_done;
    logic        w_cap_mul;
    logic        w_capture;

    // bit0 = rs1 signed, bit1 = rs2 signed
    always_comb begin
        w_dec_op  = MUL_H;
        w_dec_sgn = 2'b00;
        unique case (in_funct3_i)
            2'b00: begin
                w_dec_op  = MUL_MAC32;
                w_dec_sgn = 2'b00;
            end
            2'b01: w_dec_sgn = 2'b11;
            2'b10: w_dec_sgn = 2'b01;
            2'b11: w_dec_sgn = 2'b00;
        endcase
    end

    assign w_idle      = (r_state == IDLE);
    assign in_ready_o  = w_idle & ~flush_i & (~r_out_valid | out_ready_i);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_is_mul    = (in_funct3_i == 2'b00);
    assign w_mult_done = mult_ready_i & ~mult_multicycle_i;
    assign w_done      = ~w_idle & w_mult_done;
    assign w_cap_mul   = w_accept & w_is_mul;
    // A killed or flushed MULH still finishes in the multiplier, unseen.
    assign w_capture   = w_cap_mul | (w_done & ~r_kill & ~flush_i);

    assign mult_ex_ready_o = w_idle | w_mult_done;
    assign busy_o          = ~w_idle;
    assign out_valid_o     = r_out_valid;
    assign out_result_o    = r_out_result;
    assign out_rd_o        = r_out_rd;

    always_comb begin
        mult_enable_o       = 1'b0;
        mult_operator_o     = MUL_MAC32;
        mult_short_signed_o = 2'b00;
        mult_op_a_o         = '0;
        mult_op_b_o         = '0;
        mult_op_c_o         = '0;
        if (~w_idle) begin
            mult_operator_o     = MUL_H;
            mult_short_signed_o = r_sgn;
            mult_op_a_o         = r_a;
            mult_op_b_o         = r_b;
            mult_op_c_o         = r_opc;
        end else if (w_accept) begin
            mult_enable_o       = 1'b1;
            mult_operator_o     = w_dec_op;
            mult_short_signed_o = w_dec_sgn;
            mult_op_a_o         = in_rs1_i;
            mult_op_b_o         = in_rs2_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept & ~w_is_mul) w_state_nxt = MH_WAIT;
            MH_WAIT: if (w_mult_done) w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sgn <= '0;
            r_rd  <= '0;
        end else if (w_accept) begin
            r_a   <= in_rs1_i;
            r_b   <= in_rs2_i;
            r_sgn <= w_dec_sgn;
            r_rd  <= in_rd_i;
        end
    end

    // Partial sums of STEP0..STEP2 feed back as op_c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc <= '0;
        end else if (w_accept) begin
            r_opc <= '0;
        end else if (mult_multicycle_i) begin
            r_opc <= mult_result_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kill <= 1'b0;
        end else if (w_done) begin
            r_kill <= 1'b0;
        end else if (~w_idle & flush_i) begin
            r_kill <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= mult_result_i;
            r_out_rd     <= w_cap_mul ? in_rd_i : r_rd;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rv32imf_mult_issue.md
# rv32imf_mult_issue

- Issue and result stage wrapped around `rv32imf_mult`.
- Accepts RV32M MUL/MULH/MULHSU/MULHU from decode over a valid/ready handshake and maps funct3 to multiplier controls.
- Holds operands stable and feeds back partial results through `op_c` across the 4-step MULH sequence.
- Buffers the final result in a one-entry output register for writeback.

## Interface
Parameters: none.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  kill in-flight and buffered instruction
- in_valid_i / in_ready_o  in/out  1  decode handshake
- in_funct3_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_rs1_i, in_rs2_i  in  32  source operands
- in_rd_i  in  5  destination register
- mult_enable_o  out  1  enable to multiplier
- mult_operator_o  out  mul_opcode_e  MUL_MAC32 or MUL_H
- mult_short_signed_o  out  2  bit0 = rs1 signed, bit1 = rs2 signed
- mult_op_a_o, mult_op_b_o, mult_op_c_o  out  32  multiplier operands
- mult_ex_ready_o  out  1  ex_ready to multiplier
- mult_result_i  in  32  multiplier result
- mult_ready_i, mult_multicycle_i  in  1  multiplier status
- out_valid_o / out_ready_i  out/in  1  writeback handshake
- out_result_o  out  32  result
- out_rd_o  out  5  destination register
- busy_o  out  1  FSM not IDLE

Other multiplier inputs (subword, imm, dot, clpx) are tied to 0 at the top level.

## Operation
- **States:**
  - IDLE, MH_WAIT; reset to IDLE.
  - busy_o = (state == MH_WAIT).
- **Handshake:**
  - in_ready_o = IDLE & ~flush_i & (~out_valid_o | out_ready_i).
  - Accept = in_valid_i & in_ready_o.
  - mult_enable_o = accept.
- **Accept cycle:**
  - Operands go straight from in_rs1_i/in_rs2_i to mult_op_a_o/mult_op_b_o.
  - The same values are registered into a_q, b_q, sgn_q and rd_q.
  - mult_op_c_o = 0.
- **Funct3 mapping:**
  - 00: MUL_MAC32, signed 00 (low word is sign-agnostic).
  - 01: MUL_H, 11.
  - 10: MUL_H, 01.
  - 11: MUL_H, 00.
- **MUL:**
  - The result is combinational in the accept cycle and is captured into the output register at the clock edge.
  - State stays IDLE.
- **MULH variants:**
  - Accept moves the state to MH_WAIT.
  - While in MH_WAIT:
    - mult_operator_o = MUL_H.
    - mult_enable_o = 0.
    - Operands come from a_q/b_q/sgn_q.
  - op_c register:
    - Cleared on accept.
    - Loads mult_result_i every cycle that mult_multicycle_i = 1 (the STEP0, STEP1 and STEP2 partial sums).
    - Drives mult_op_c_o in MH_WAIT.
  - Completion is mult_ready_i & ~mult_multicycle_i, which occurs in the multiplier's FINISH step. On completion:
    - Capture mult_result_i and rd_q.
    - Assert mult_ex_ready_o.
    - Return to IDLE.
- **mult_ex_ready_o** = IDLE | (mult_ready_i & ~mult_multicycle_i).
- **IDLE with no accept:** mult_operator_o = MUL_MAC32, operands 0.
- **Output register:**
  - out_valid set on capture.
  - out_valid cleared on out_ready_i & ~capture.
  - A capture never meets a full register; the in_ready_o rule guarantees it is free.
- **Flush:**
  - Clears out_valid_o and blocks accept in the same cycle.
  - In MH_WAIT it sets kill_q. The multiplier still runs to FINISH and mult_ex_ready_o still pulses, but the capture is suppressed and kill_q clears on the return to IDLE.
  - A flush in the completion cycle also suppresses the capture.
- **Reset mid-MULH:**
  - State returns to IDLE; kill_q, op_c and the output register clear.
  - The multiplier resets on the same rst_n.

## Timing
- **Reset values:**
  - out_valid_o = 0, out_result_o = 0, out_rd_o = 0, busy_o = 0.
  - mult_enable_o = 0, mult_op_c_o = 0.
  - mult_ex_ready_o = 1.
  - in_ready_o = 1 (flush_i low).
- **MUL:** accept at cycle N, out_valid_o at N+1. Back-to-back throughput is 1 per cycle when out_ready_i = 1.
- **MULH:**
  - Accept at N; multiplier STEP0/STEP1/STEP2 at N+1..N+3; FINISH and capture at N+4; out_valid_o at N+5.
  - in_ready_o is low during N+1..N+4.
- out_valid_o/out_result_o/out_rd_o hold stable while out_ready_i = 0.
- Simultaneous pop and accept of a MUL: the register reloads with no bubble.

## Test plan
- **MUL back-to-back:** MUL 7 × 0xFFFFFFFD, then MUL 0x10000 × 0x10000, out_ready = 1 → 0xFFFFFFEB at N+1 and 0x00000000 at N+2; rd carried correctly.
- **MULH:** 0x80000000 × 0x80000000 → 0x40000000 at N+5; busy_o high for cycles N+1..N+4.
- **MULHU / MULHSU:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHSU 0x00000002 × 0x80000000 → 0x00000001.
- **Backpressure:** out_ready = 0 after a MUL result → out_valid and data hold, in_ready_o = 0; raising out_ready with a new MUL valid gives a same-cycle pop and accept.
- **Flush in STEP1 of MULH:** no out_valid; mult_ex_ready_o pulses at N+4; in_ready_o = 1 at N+5; a following MUL 3 × 5 → 0x0000000F.
- **rst_n asserted in STEP2:** all outputs return to their reset values immediately; a new MULH after release → correct result.
